// File: rtl/matrix_streamer_pkg.sv
// Shared defaults, FSM encoding and index-stepping helper for matrix_streamer.
package matrix_streamer_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned MAX_DIM_DEF    = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Advance a (slow, fast) index pair; fast wraps to 0 at dim and bumps slow.
    function automatic logic [3:0] step_idx(input logic [1:0] slow,
                                            input logic [1:0] fast,
                                            input logic [1:0] dim);
        if (fast == dim) begin
            return {slow + 2'd1, 2'd0};
        end
        return {slow, fast + 2'd1};
    endfunction

endpackage

// File: rtl/matrix_streamer_stream_fifo2.sv
// stream_fifo2: two-entry valid/ready buffer; head entry is held stable until popped.
module stream_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = (count_q != 2'd0) && rd_ready_i;
        push     = wr_valid_i && ((count_q != 2'd2) || pop);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign rd_valid_o = (count_q != 2'd0);
    assign count_o    = count_q;

endmodule

// File: rtl/matrix_streamer.sv
// Streams a (dim+1)^2 matrix from the operand register in row- or column-major order.
// Column-major order is only built when STREAMER_TRANSPOSE_EN is defined.
module matrix_streamer
    import matrix_streamer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned MAX_DIM    = MAX_DIM_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            dim_i,
    input  logic                  transpose_i,
    output logic [ADDR_WIDTH-1:0] addr_Mat_o,
    input  logic [DATA_WIDTH-1:0] read_data_Mat_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    logic [1:0]            state_q, state_d;
    logic [1:0]            dim_q, dim_d;
    logic [1:0]            row_q, row_d;
    logic [1:0]            col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
`ifdef STREAMER_TRANSPOSE_EN
    logic                  transpose_q, transpose_d;
`else
    logic                  unused_transpose;
    assign unused_transpose = transpose_i;
`endif

    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_data;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  issue;
    logic                  elem_last;
    logic [2:0]            credit;

    always_comb begin
        state_d  = state_q;
        dim_d    = dim_q;
        row_d    = row_q;
        col_d    = col_q;
        addr_d   = addr_q;
`ifdef STREAMER_TRANSPOSE_EN
        transpose_d = transpose_q;
`endif
        pop       = fifo_valid && ready_i;
        // Occupancy after this cycle's transfer, so a drain and a refill can overlap.
        credit    = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
        issue     = (state_q == ST_FETCH) && (credit < 3'd2);
        elem_last = (row_q == dim_q) && (col_q == dim_q);
        inflight_d      = issue;
        inflight_last_d = issue && elem_last;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    dim_d   = dim_i;
                    row_d   = '0;
                    col_d   = '0;
`ifdef STREAMER_TRANSPOSE_EN
                    transpose_d = transpose_i;
`endif
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_d = ADDR_WIDTH'(32'(row_q) * MAX_DIM + 32'(col_q));
`ifdef STREAMER_TRANSPOSE_EN
                    if (transpose_q) begin
                        {col_d, row_d} = step_idx(col_q, row_q, dim_q);
                    end else begin
                        {row_d, col_d} = step_idx(row_q, col_q, dim_q);
                    end
`else
                    {row_d, col_d} = step_idx(row_q, col_q, dim_q);
`endif
                    if (elem_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_data[DATA_WIDTH]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            dim_q           <= '0;
            row_q           <= '0;
            col_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef STREAMER_TRANSPOSE_EN
            transpose_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            dim_q           <= dim_d;
            row_q           <= row_d;
            col_q           <= col_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
`ifdef STREAMER_TRANSPOSE_EN
            transpose_q     <= transpose_d;
`endif
        end
    end

    stream_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_valid_i(inflight_q),
        .wr_data_i ({inflight_last_q, read_data_Mat_i}),
        .rd_data_o (fifo_data),
        .rd_valid_o(fifo_valid),
        .rd_ready_i(ready_i),
        .count_o   (fifo_count)
    );

    // The address is presented in the issuing cycle and otherwise holds the last one read.
    assign addr_Mat_o = addr_d;
    assign data_o     = fifo_data[DATA_WIDTH-1:0];
    assign valid_o    = fifo_valid;
    assign last_o     = fifo_valid && fifo_data[DATA_WIDTH];
    assign busy_o     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_streamer.sv
// Self-checking bench for matrix_streamer: directed table, random streams and a mid-stream reset.
module tb_matrix_streamer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  dim_i;
    logic        transpose_i;
    logic [3:0]  addr_Mat_o;
    logic [31:0] read_data_Mat_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        busy_o;
    logic        done_o;

    logic [31:0] mem [16];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    // Operand register: synchronous read, data valid the cycle after the address.
    always @(posedge clk) read_data_Mat_i <= mem[addr_Mat_o];

    matrix_streamer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .MAX_DIM   (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .dim_i          (dim_i),
        .transpose_i    (transpose_i),
        .addr_Mat_o     (addr_Mat_o),
        .read_data_Mat_i(read_data_Mat_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .last_o         (last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    typedef struct {
        logic [1:0]  dim;
        logic        tr;
        int unsigned mode;
        bit          restart;
        int unsigned exp_n;
        bit          has_second;
        int unsigned exp_second;
        int unsigned exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fill_scaled();
        for (int i = 0; i < 16; i++) mem[i] = 32'(i * 10);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
    endtask

    function automatic logic ready_for(input int unsigned mode, input int unsigned k);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[k % 4];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_stream(input logic [1:0] dim, input logic tr, input int unsigned mode,
                              input bit restart, input int unsigned exp_n, input bit has_second,
                              input int unsigned exp_second, input int unsigned exp_last, input bit has_last);
        int unsigned exp_q[$];
        int unsigned got_q[$];
        int unsigned xfers, done_cnt, done_cyc, last_cyc, first_valid, first_xfer, k, exp_v;
        bit          prev_stall, finished, busy_at_done, col_major;
        logic [31:0] prev_data;
        logic        prev_last;

        `ifdef STREAMER_TRANSPOSE_EN
        col_major = tr;
        `else
        col_major = tr & 1'b0;
        `endif
        // Reference order: outer index is the slow one, element (r,c) lives at r*4+c.
        for (int o = 0; o <= int'(dim); o++) begin
            for (int i = 0; i <= int'(dim); i++) begin
                if (col_major) exp_q.push_back(mem[i * 4 + o]);
                else           exp_q.push_back(mem[o * 4 + i]);
            end
        end

        xfers = 0; done_cnt = 0; done_cyc = 0; last_cyc = 0; first_valid = 0; first_xfer = 0;
        prev_stall = 1'b0; finished = 1'b0; busy_at_done = 1'b1;
        prev_data = '0; prev_last = 1'b0;

        @(negedge clk);
        start_i     = 1'b1;
        dim_i       = dim;
        transpose_i = tr;
        ready_i     = ready_for(mode, 0);

        for (k = 1; k <= 400 && !finished; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 1) check("busy_after_start", busy_o, 1);
            if (prev_stall) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o, prev_data);
                check("stall_last", last_o, prev_last);
            end
            ready_i = ready_for(mode, k);
            if (done_o) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc     = k;
                    busy_at_done = busy_o;
                end
            end
            if (valid_o && first_valid == 0) first_valid = k;
            if (valid_o && ready_i) begin
                if (restart && xfers == 2) begin
                    start_i = 1'b1;
                    dim_i   = 2'd0;
                end
                if (xfers == 0) first_xfer = k;
                xfers++;
                last_cyc = k;
                got_q.push_back(data_o);
                if (exp_q.size() == 0) begin
                    check("extra_transfer", data_o, 0);
                    check("extra_transfer_count", xfers, exp_n);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("data", data_o, exp_v);
                    check("last_flag", last_o, (exp_q.size() == 0) ? 1 : 0);
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
            if (done_cnt > 0 && k >= done_cyc + 2) finished = 1'b1;
        end

        check("stream_finished", finished, 1);
        check("transfer_count", xfers, exp_n);
        check("leftover_expected", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("done_after_last", done_cyc, last_cyc + 1);
        check("busy_low_at_done", busy_at_done, 0);
        check("addr_hold", addr_Mat_o, 32'(dim) * 5);
        if (mode == 0) begin
            // Accepting edge is at k=0; two edges later valid is visible at k=3.
            check("first_valid_latency", first_valid, 3);
            check("back_to_back", last_cyc - first_xfer, xfers - 1);
        end
        if (has_second) check("second_value", (got_q.size() > 1) ? got_q[1] : 32'hdead_beef, exp_second);
        if (has_last)   check("last_value", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 32'hdead_beef, exp_last);
        ready_i = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"},  addr_Mat_o, 0);
        check({tag, "_data"},  data_o, 0);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_last"},  last_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
    endtask

    initial begin
        int unsigned cnt, guard, rd;
        logic [1:0]  rdim;

        vecs[0] = '{2'd3, 1'b0, 0, 1'b0, 16, 1'b1, 10, 150};
`ifdef STREAMER_TRANSPOSE_EN
        vecs[1] = '{2'd1, 1'b1, 0, 1'b0, 4, 1'b1, 40, 50};
        vecs[4] = '{2'd2, 1'b1, 1, 1'b0, 9, 1'b1, 40, 100};
`else
        vecs[1] = '{2'd1, 1'b1, 0, 1'b0, 4, 1'b1, 10, 50};
        vecs[4] = '{2'd2, 1'b1, 1, 1'b0, 9, 1'b1, 10, 100};
`endif
        vecs[2] = '{2'd3, 1'b0, 1, 1'b0, 16, 1'b1, 10, 150};
        vecs[3] = '{2'd3, 1'b0, 0, 1'b1, 16, 1'b1, 10, 150};
        vecs[5] = '{2'd0, 1'b0, 0, 1'b0, 1, 1'b0, 0, 0};

        rst_ni = 1'b0; start_i = 1'b0; dim_i = '0; transpose_i = 1'b0; ready_i = 1'b1;
        fill_scaled();
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fill_scaled();
            run_stream(vecs[v].dim, vecs[v].tr, vecs[v].mode, vecs[v].restart, vecs[v].exp_n,
                       vecs[v].has_second, vecs[v].exp_second, vecs[v].exp_last, 1'b1);
        end

        for (int r = 0; r < 8; r++) begin
            fill_random();
            rdim = 2'($urandom_range(0, 3));
            rd   = int'(rdim) + 1;
            run_stream(rdim, 1'($urandom_range(0, 1)), 2, 1'b0, rd * rd, 1'b0, 0, 0, 1'b0);
        end

        // Mid-stream reset after the fifth transfer, then a 1x1 stream.
        fill_scaled();
        @(negedge clk);
        start_i = 1'b1; dim_i = 2'd3; transpose_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cnt = 0; guard = 0;
        if (valid_o && ready_i) cnt++;
        while (cnt < 5 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (valid_o && ready_i) cnt++;
        end
        check("pre_reset_transfers", cnt, 5);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        check_outputs_zero("abort_hold");
        rst_ni = 1'b1;
        run_stream(2'd0, 1'b0, 0, 1'b0, 1, 1'b0, 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_streamer.md
MATRIX_STREAMER -- requirements
Module: matrix_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one matrix element.
REQ-002 Parameter ADDR_WIDTH, default 4, operand-register address width.
REQ-003 Parameter MAX_DIM, default 4, maximum matrix side; MAX_DIM*MAX_DIM SHALL equal 2**ADDR_WIDTH.
REQ-004 Port clk_i, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 Port start_i, input, 1, one-cycle pulse starting a stream; ignored unless idle.
REQ-007 Port dim_i, input, 2, matrix side minus one (0..3 -> 1x1..4x4), sampled on accepted start_i.
REQ-008 Port transpose_i, input, 1, column-major order request, sampled on accepted start_i.
REQ-009 Port addr_Mat_o, output, ADDR_WIDTH, read address to the operand register.
REQ-010 Port read_data_Mat_i, input, DATA_WIDTH, operand register data, valid one cycle after addr_Mat_o is issued.
REQ-011 Port data_o, output, DATA_WIDTH, streamed element.
REQ-012 Port valid_o, output, 1, data_o holds a valid element.
REQ-013 Port ready_i, input, 1, downstream accepts; transfer when valid_o && ready_i.
REQ-014 Port last_o, output, 1, marks the final element of the stream, qualified by valid_o.
REQ-015 Port busy_o, output, 1, high from accepted start_i until done_o.
REQ-016 Port done_o, output, 1, one-cycle pulse after the last transfer.

Function
REQ-017 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start_i; FETCH->DRAIN when the last read is issued; DRAIN->DONE when the last element transfers; DONE->IDLE unconditionally next cycle.
REQ-018 Element count SHALL be (dim_i+1)^2; row r, column c SHALL be read from address r*MAX_DIM+c.
REQ-019 Row-major order: c increments fastest, wraps to 0 at dim, then r increments.
REQ-020 Transpose order: r increments fastest, wraps to 0 at dim, then c increments; address formula unchanged.
REQ-021 A 2-entry output buffer SHALL absorb the one-cycle read latency; a read is issued only when buffered plus in-flight elements < 2.
REQ-022 With ready_i held high, first valid_o SHALL assert 2 cycles after accepted start_i and one element SHALL transfer per cycle thereafter.
REQ-023 data_o, valid_o, last_o SHALL remain stable while valid_o && !ready_i.
REQ-024 start_i while busy_o SHALL be ignored with no state change.
REQ-025 addr_Mat_o SHALL hold its last value when no read is issued.
REQ-026 Block SHALL never drive writes to the operand register.

Reset
REQ-027 On rst_ni low, asynchronously: FSM=IDLE, buffer empty, counters 0, addr_Mat_o=0, data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
REQ-028 Reset mid-stream SHALL abort the stream with no done_o pulse; in-flight data SHALL be discarded.

Configuration
REQ-029 Macro STREAMER_TRANSPOSE_EN defined: transpose_i honoured per REQ-020.
REQ-030 Macro STREAMER_TRANSPOSE_EN undefined: transpose_i port present but ignored; order always row-major; column-major counter logic absent.

Structure
REQ-031 Shared package SHALL hold DATA_WIDTH, ADDR_WIDTH, MAX_DIM defaults and the FSM state encoding.
REQ-032 One sub-module, stream_fifo2 (2-entry valid/ready buffer), SHALL implement REQ-021/REQ-023.

Verification
REQ-033 Operand register preloaded with value = address*10; start_i, dim_i=3, ready_i=1 -> 16 transfers 0,10,...,150 on consecutive cycles, last_o on 150, done_o one cycle later.
REQ-034 Same preload, dim_i=1, transpose_i=1 (macro defined) -> transfers 0,40,10,50, last_o on 50.
REQ-035 Same preload, dim_i=1, transpose_i=1, macro undefined -> transfers 0,10,40,50.
REQ-036 dim_i=3, ready_i toggled 1,0,0,1 repeating -> all 16 values in order, none duplicated or lost, data_o stable across stalls.
REQ-037 start_i pulsed again on 3rd transfer -> ignored, exactly 16 transfers, single done_o.
REQ-038 rst_ni low after 5th transfer, then start_i with dim_i=0 -> all outputs 0 during reset; single transfer of value 0 with last_o=1.
